// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the WB/MDU/decode side and the register-file write-port arbiter.
interface regfile_wb_arbiter_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             wb_we;
  logic [4:0]       wb_reg;
  logic [31:0]      wb_data;
  logic             mdu_valid;
  logic             mdu_ready;
  logic [4:0]       mdu_reg;
  logic [31:0]      mdu_data;
  logic [4:0]       rd_reg1;
  logic [4:0]       rd_reg2;
  logic             pend_hit;
  logic             stall_req;
  logic             rf_we;
  logic [4:0]       rf_reg;
  logic [31:0]      rf_data;
  logic [CNT_W-1:0] pend_count;

  modport master (
    output wb_we, wb_reg, wb_data, mdu_valid, mdu_reg, mdu_data, rd_reg1, rd_reg2,
    input  mdu_ready, pend_hit, stall_req, rf_we, rf_reg, rf_data, pend_count
  );

  modport slave (
    input  wb_we, wb_reg, wb_data, mdu_valid, mdu_reg, mdu_data, rd_reg1, rd_reg2,
    output mdu_ready, pend_hit, stall_req, rf_we, rf_reg, rf_data, pend_count
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between WB (priority) and a FIFO of pending MDU results,
// with WAW squash of queued entries, pending-hazard lookup and a drain stall request.
module regfile_wb_arbiter #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_WAIT = 3
) (
  input logic                 clk,
  input logic                 rst_n,
  regfile_wb_arbiter_if.slave bus
);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  logic [4:0]        r_reg  [DEPTH];
  logic [31:0]       r_data [DEPTH];
  logic              r_vld  [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [WAIT_W-1:0] r_wait;

  logic w_wb_active;
  logic w_empty;
  logic w_full;
  logic w_head_vld;
  logic w_head_sq;
  logic w_pop;
  logic w_push;
  logic w_hit;

  assign w_wb_active = bus.wb_we && (bus.wb_reg != 5'd0);
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign w_head_vld  = !w_empty && r_vld[r_rd_ptr];
  assign w_head_sq   = !w_empty && !r_vld[r_rd_ptr];
  // A squashed head always retires immediately; a live head only gets the port when WB is idle.
  assign w_pop       = w_head_sq || (w_head_vld && !w_wb_active);
  assign w_push      = bus.mdu_valid && !w_full && (bus.mdu_reg != 5'd0);

  assign bus.mdu_ready  = !w_full;
  assign bus.pend_count = r_count;
  assign bus.pend_hit   = w_hit;
  assign bus.stall_req  = (r_wait == WAIT_W'(MAX_WAIT)) || (w_full && bus.mdu_valid);

  // Write-port select
  always_comb begin
    bus.rf_we   = 1'b0;
    bus.rf_reg  = 5'd0;
    bus.rf_data = 32'd0;
    if (w_wb_active) begin
      bus.rf_we   = 1'b1;
      bus.rf_reg  = bus.wb_reg;
      bus.rf_data = bus.wb_data;
    end else if (w_head_vld) begin
      bus.rf_we   = 1'b1;
      bus.rf_reg  = r_reg[r_rd_ptr];
      bus.rf_data = r_data[r_rd_ptr];
    end
  end

  // Pending hazard lookup against live queued entries only
  always_comb begin
    w_hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (r_vld[i] &&
          (((r_reg[i] == bus.rd_reg1) && (bus.rd_reg1 != 5'd0)) ||
           ((r_reg[i] == bus.rd_reg2) && (bus.rd_reg2 != 5'd0))))
        w_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_wait   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_vld[i]  <= 1'b0;
        r_reg[i]  <= 5'd0;
        r_data[i] <= 32'd0;
      end
    end else begin
      // Later assignments win: the freshly pushed slot is never squashed by the same-cycle WB.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (w_wb_active && (r_reg[i] == bus.wb_reg))
          r_vld[i] <= 1'b0;
        if (w_pop && (PTR_W'(i) == r_rd_ptr))
          r_vld[i] <= 1'b0;
        if (w_push && (PTR_W'(i) == r_wr_ptr)) begin
          r_vld[i]  <= 1'b1;
          r_reg[i]  <= bus.mdu_reg;
          r_data[i] <= bus.mdu_data;
        end
      end
      if (w_push)
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      if (w_pop || w_empty)
        r_wait <= '0;
      else if (w_head_vld && w_wb_active && (r_wait != WAIT_W'(MAX_WAIT)))
        r_wait <= r_wait + WAIT_W'(1);
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: expected MDU writes are queued at push time
// and matched against non-WB register-file writes observed on the falling edge.
module tb_regfile_wb_arbiter;
  logic clk;
  logic rst_n;

  regfile_wb_arbiter_if #(.DEPTH(4)) bus ();

  regfile_wb_arbiter #(.DEPTH(4), .MAX_WAIT(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] rf_model [32];
  int          n_checks = 0;
  int          n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.wb_we     = 1'b0;
    bus.wb_reg    = 5'd0;
    bus.wb_data   = 32'd0;
    bus.mdu_valid = 1'b0;
    bus.mdu_reg   = 5'd0;
    bus.mdu_data  = 32'd0;
    bus.rd_reg1   = 5'd0;
    bus.rd_reg2   = 5'd0;
  endtask

  task automatic push_mdu(input logic [4:0] r, input logic [31:0] d, input bit expect_write);
    wr_t e;
    bus.mdu_valid = 1'b1;
    bus.mdu_reg   = r;
    bus.mdu_data  = d;
    e.r = r;
    e.d = d;
    if (expect_write) exp_q.push_back(e);
  endtask

  task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
    bus.wb_we   = 1'b1;
    bus.wb_reg  = r;
    bus.wb_data = d;
  endtask

  // Write-port monitor: WB writes must pass straight through, all others come from the queue
  always @(negedge clk) begin
    wr_t e;
    if (bus.wb_we && (bus.wb_reg != 5'd0)) begin
      check("wb_rf_we",   32'(bus.rf_we),  32'd1);
      check("wb_rf_reg",  32'(bus.rf_reg), 32'(bus.wb_reg));
      check("wb_rf_data", bus.rf_data,     bus.wb_data);
    end else if (bus.rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_extra_write", 32'(bus.rf_we), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_reg",  32'(bus.rf_reg), 32'(e.r));
        check("sb_data", bus.rf_data,     e.d);
      end
    end
    if (bus.rf_we === 1'b1) rf_model[bus.rf_reg] = bus.rf_data;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) rf_model[i] = 32'd0;
    rst_n = 1'b0;
    idle();
    wb_write(5'd4, 32'h4444_0000);
    bus.rd_reg1 = 5'd4;
    mid();
    check("rst_count",  32'(bus.pend_count), 32'd0);
    check("rst_ready",  32'(bus.mdu_ready),  32'd1);
    check("rst_hit",    32'(bus.pend_hit),   32'd0);
    check("rst_stall",  32'(bus.stall_req),  32'd0);

    // First push right after reset release, then a one-cycle-later drain
    next_cycle();
    rst_n = 1'b1;
    idle();
    push_mdu(5'd5, 32'hDEAD_BEEF, 1'b1);
    mid();
    check("t1_nobypass", 32'(bus.rf_we),      32'd0);
    check("t1_cnt0",     32'(bus.pend_count), 32'd0);
    next_cycle();
    idle();
    bus.rd_reg1 = 5'd5;
    mid();
    check("t1_cnt1", 32'(bus.pend_count), 32'd1);
    check("t1_hit",  32'(bus.pend_hit),   32'd1);
    check("t1_we",   32'(bus.rf_we),      32'd1);
    next_cycle();
    mid();
    check("t1_cnt_end", 32'(bus.pend_count), 32'd0);
    check("t1_hit_end", 32'(bus.pend_hit),   32'd0);
    check("t1_sb",      32'(exp_q.size()),   32'd0);

    // Head blocked by WB for four cycles raises the wait stall
    next_cycle();
    idle();
    push_mdu(5'd3, 32'h11, 1'b1);
    mid();
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      idle();
      wb_write(5'd7, 32'h7000 + 32'(i));
      mid();
      check("t2_stall", 32'(bus.stall_req), (i == 3) ? 32'd1 : 32'd0);
      check("t2_rfreg", 32'(bus.rf_reg),    32'd7);
    end
    next_cycle();
    idle();
    mid();
    check("t2_drain_reg",   32'(bus.rf_reg),    32'd3);
    check("t2_stall_hold",  32'(bus.stall_req), 32'd1);
    next_cycle();
    mid();
    check("t2_stall_fall", 32'(bus.stall_req),  32'd0);
    check("t2_cnt",        32'(bus.pend_count), 32'd0);
    check("t2_sb",         32'(exp_q.size()),   32'd0);

    // Fill the FIFO under WB traffic, reject a fifth result, then drain in order
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      idle();
      wb_write(5'd20, 32'(i));
      push_mdu(5'(i + 1), 32'hC0 + 32'(i), 1'b1);
      mid();
      check("t3_ready", 32'(bus.mdu_ready), 32'd1);
    end
    next_cycle();
    idle();
    wb_write(5'd20, 32'h20);
    push_mdu(5'd30, 32'hBAD, 1'b0);
    mid();
    check("t3_full_ready", 32'(bus.mdu_ready),  32'd0);
    check("t3_full_stall", 32'(bus.stall_req),  32'd1);
    check("t3_full_cnt",   32'(bus.pend_count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      idle();
      mid();
      check("t3_drain_we", 32'(bus.rf_we), 32'd1);
      if (i == 0) check("t3_no_accept", 32'(bus.pend_count), 32'd4);
    end
    next_cycle();
    mid();
    check("t3_cnt", 32'(bus.pend_count), 32'd0);
    check("t3_sb",  32'(exp_q.size()),   32'd0);

    // WAW squash: younger WB write to r9 kills the queued r9 result
    next_cycle();
    idle();
    push_mdu(5'd9, 32'hAA, 1'b0);
    mid();
    next_cycle();
    idle();
    wb_write(5'd9, 32'hBB);
    bus.rd_reg2 = 5'd9;
    mid();
    check("t4_hit_pre", 32'(bus.pend_hit), 32'd1);
    next_cycle();
    idle();
    bus.rd_reg1 = 5'd9;
    mid();
    check("t4_hit_post",  32'(bus.pend_hit),   32'd0);
    check("t4_sq_nowe",   32'(bus.rf_we),      32'd0);
    check("t4_sq_cnt",    32'(bus.pend_count), 32'd1);
    next_cycle();
    idle();
    mid();
    check("t4_cnt",   32'(bus.pend_count), 32'd0);
    check("t4_r9",    rf_model[9],         32'hBB);

    // Writes targeting r0 from either source are dropped
    next_cycle();
    idle();
    push_mdu(5'd0, 32'h55, 1'b0);
    mid();
    check("t5_ready", 32'(bus.mdu_ready), 32'd1);
    next_cycle();
    idle();
    wb_write(5'd0, 32'h66);
    mid();
    check("t5_cnt",  32'(bus.pend_count), 32'd0);
    check("t5_wb0",  32'(bus.rf_we),      32'd0);
    next_cycle();
    idle();
    mid();
    check("t5_nowe", 32'(bus.rf_we), 32'd0);

    // Back-to-back push/pop across pointer wrap keeps the count at one
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      idle();
      push_mdu(5'(16 + i), 32'hA0 + 32'(i), 1'b1);
      mid();
      if (i > 0) check("t6_cnt_steady", 32'(bus.pend_count), 32'd1);
    end
    next_cycle();
    idle();
    mid();
    next_cycle();
    mid();
    check("t6_cnt", 32'(bus.pend_count), 32'd0);
    check("t6_sb",  32'(exp_q.size()),   32'd0);

    // Reset in the middle of a drain discards the rest of the queue
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      idle();
      wb_write(5'd20, 32'h300 + 32'(i));
      push_mdu(5'(11 + i), 32'h1100 + 32'(i), i == 0);
      mid();
    end
    next_cycle();
    idle();
    mid();
    check("t7_cnt3",  32'(bus.pend_count), 32'd3);
    check("t7_first", 32'(bus.rf_reg),     32'd11);
    next_cycle();
    idle();
    rst_n = 1'b0;
    bus.rd_reg1 = 5'd12;
    mid();
    check("t7_rst_cnt",   32'(bus.pend_count), 32'd0);
    check("t7_rst_ready", 32'(bus.mdu_ready),  32'd1);
    check("t7_rst_hit",   32'(bus.pend_hit),   32'd0);
    check("t7_rst_stall", 32'(bus.stall_req),  32'd0);
    check("t7_rst_we",    32'(bus.rf_we),      32'd0);
    next_cycle();
    rst_n = 1'b1;
    idle();
    push_mdu(5'd14, 32'h1414, 1'b1);
    mid();
    check("t7_rel_cnt", 32'(bus.pend_count), 32'd0);
    next_cycle();
    idle();
    mid();
    check("t7_push_cnt", 32'(bus.pend_count), 32'd1);
    check("t7_push_we",  32'(bus.rf_we),      32'd1);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      mid();
    end
    check("t7_cnt",   32'(bus.pend_count), 32'd0);
    check("final_sb", 32'(exp_q.size()),   32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
